// File: rtl/battleship_pkg.sv
// Shared types for the battleship board datapath:
// board size, FSM state and shot outcome encodings.
package battleship_pkg;

  localparam int BOARD_W = 16;

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    PLAY  = 2'd1,
    DEAD  = 2'd2
  } board_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    MISS = 2'd1,
    HIT  = 2'd2,
    BAD  = 2'd3
  } shot_result_t;

endpackage

// File: rtl/popcount.sv
// Combinational population count of a W-bit vector.
// Result is wide enough to hold W itself.
module popcount #(
  parameter int W = 16
) (
  input  logic [W-1:0]           in,
  output logic [$clog2(W+1)-1:0] cnt
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(in[i]);
    end
  end

endmodule

// File: rtl/shot_register.sv
// One player's board: locked ship map, accumulated shot map,
// remaining lives and the outcome of the last attack.
module shot_register
  import battleship_pkg::*;
#(
  parameter int BOARD_W = battleship_pkg::BOARD_W
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic                         ship_ld,
  input  logic                         shot_ld,
  input  logic [BOARD_W-1:0]           ship_sw,
  input  logic [BOARD_W-1:0]           shot_sw,
  output logic                         shot_ok,
  output logic                         alive,
  output logic [1:0]                   result,
  output logic [BOARD_W-1:0]           ships,
  output logic [BOARD_W-1:0]           shots,
  output logic [$clog2(BOARD_W+1)-1:0] lives
);

  localparam int LW = $clog2(BOARD_W + 1);

  board_state_t        state_q, state_d;
  shot_result_t        result_q, result_d;
  logic [BOARD_W-1:0]  ships_q, ships_d;
  logic [BOARD_W-1:0]  shots_q, shots_d;
  logic [LW-1:0]       lives_q, lives_d;

  logic [BOARD_W-1:0]  new_cells;
  logic [LW-1:0]       new_cnt;
  logic [LW-1:0]       ship_cnt;
  logic                hit;

  assign new_cells = shot_sw & ~shots_q;
  assign hit       = |(new_cells & ships_q);

  popcount #(.W(BOARD_W)) u_pc_new (
    .in  (new_cells),
    .cnt (new_cnt)
  );

  popcount #(.W(BOARD_W)) u_pc_ship (
    .in  (ship_sw),
    .cnt (ship_cnt)
  );

  // Exactly one fresh cell, and every earlier shot kept.
  assign shot_ok = (new_cnt == LW'(1))
                && ((shot_sw & shots_q) == shots_q)
                && (state_q != DEAD);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ships_d  = ships_q;
    shots_d  = shots_q;
    lives_d  = lives_q;

    if (shot_ld && state_q != DEAD) begin
      if (shot_ok) begin
        shots_d = shot_sw;
        if (hit && lives_q != '0) begin
          result_d = HIT;
          lives_d  = lives_q - LW'(1);
        end else begin
          result_d = MISS;
        end
      end else begin
        result_d = BAD;
      end
      state_d = (lives_d == '0) ? DEAD : PLAY;
    end else if (shot_ld) begin
      result_d = BAD;
    end else if (ship_ld && state_q == SETUP) begin
      ships_d = ship_sw;
      lives_d = ship_cnt;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= SETUP;
      result_q <= NONE;
      ships_q  <= '0;
      shots_q  <= '0;
      lives_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ships_q  <= ships_d;
      shots_q  <= shots_d;
      lives_q  <= lives_d;
    end
  end

  assign alive  = (state_q != DEAD);
  assign result = result_q;
  assign ships  = ships_q;
  assign shots  = shots_q;
  assign lives  = lives_q;

endmodule

// File: tb/tb_shot_register.sv
// Directed-vector bench for shot_register: stimulus pushes
// expected outputs, a negedge monitor pops and compares.
module tb_shot_register;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        ship_ld = 1'b0;
  logic        shot_ld = 1'b0;
  logic [15:0] ship_sw = '0;
  logic [15:0] shot_sw = '0;
  logic        shot_ok;
  logic        alive;
  logic [1:0]  result;
  logic [15:0] ships;
  logic [15:0] shots;
  logic [4:0]  lives;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        ok;
    logic        alive;
    logic [1:0]  res;
    logic [15:0] ships;
    logic [15:0] shots;
    logic [4:0]  lives;
  } exp_t;

  exp_t sb[$];

  shot_register #(.BOARD_W(16)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .ship_ld (ship_ld),
    .shot_ld (shot_ld),
    .ship_sw (ship_sw),
    .shot_sw (shot_sw),
    .shot_ok (shot_ok),
    .alive   (alive),
    .result  (result),
    .ships   (ships),
    .shots   (shots),
    .lives   (lives)
  );

  always #5 clk = ~clk;

  task automatic push(input string n, input logic ok,
                      input logic al, input logic [1:0] rs,
                      input logic [15:0] sh,
                      input logic [15:0] st,
                      input logic [4:0] lv);
    exp_t e;
    e.name  = n;
    e.ok    = ok;
    e.alive = al;
    e.res   = rs;
    e.ships = sh;
    e.shots = st;
    e.lives = lv;
    sb.push_back(e);
  endtask

  task automatic drive(input logic sl, input logic hl,
                       input logic [15:0] ssw,
                       input logic [15:0] hsw);
    @(posedge clk);
    #2;
    ship_ld = sl;
    shot_ld = hl;
    ship_sw = ssw;
    shot_sw = hsw;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if ({shot_ok, alive, result, ships, shots, lives} !==
          {e.ok, e.alive, e.res, e.ships, e.shots, e.lives}) begin
        n_bad++;
        $display("FAIL %s: got ok=%b alive=%b res=%0d ships=%h shots=%h lives=%0d, want ok=%b alive=%b res=%0d ships=%h shots=%h lives=%0d",
                 e.name, shot_ok, alive, result, ships, shots, lives,
                 e.ok, e.alive, e.res, e.ships, e.shots, e.lives);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    drive(0, 0, 16'h0000, 16'h0000);
    clr_n = 1'b1;
    push("reset", 0, 1, 0, 16'h0000, 16'h0000, 0);

    drive(1, 0, 16'h000F, 16'h0000);
    drive(0, 0, 16'h000F, 16'h0001);
    push("ship_load", 1, 1, 0, 16'h000F, 16'h0000, 4);
    drive(0, 1, 16'h000F, 16'h0001);
    push("hit_pre", 1, 1, 0, 16'h000F, 16'h0000, 4);
    drive(0, 0, 16'h000F, 16'h0101);
    push("hit", 1, 1, 2, 16'h000F, 16'h0001, 3);
    drive(0, 1, 16'h000F, 16'h0101);
    drive(0, 0, 16'h000F, 16'h0006);
    push("miss", 0, 1, 1, 16'h000F, 16'h0101, 3);
    drive(0, 1, 16'h000F, 16'h0006);
    drive(0, 0, 16'h000F, 16'h0000);
    push("bad", 0, 1, 3, 16'h000F, 16'h0101, 3);
    drive(0, 0, 16'h000F, 16'h0107);
    push("two_new", 0, 1, 3, 16'h000F, 16'h0101, 3);
    drive(1, 0, 16'hFFFF, 16'h0103);
    drive(0, 0, 16'hFFFF, 16'h0103);
    push("ld_locked", 1, 1, 3, 16'h000F, 16'h0101, 3);
    drive(0, 1, 16'hFFFF, 16'h0103);
    drive(0, 0, 16'hFFFF, 16'h0107);
    push("hit2", 1, 1, 2, 16'h000F, 16'h0103, 2);
    drive(0, 1, 16'hFFFF, 16'h0107);
    drive(0, 0, 16'hFFFF, 16'h010F);
    push("hit3", 1, 1, 2, 16'h000F, 16'h0107, 1);
    drive(0, 1, 16'hFFFF, 16'h010F);
    drive(0, 0, 16'hFFFF, 16'h011F);
    push("sunk", 0, 0, 2, 16'h000F, 16'h010F, 0);
    drive(0, 1, 16'hFFFF, 16'h011F);
    drive(0, 0, 16'hFFFF, 16'h011F);
    push("dead_shot", 0, 0, 3, 16'h000F, 16'h010F, 0);

    drive(0, 0, 16'h0000, 16'h0000);
    clr_n = 1'b0;
    push("rst_dead", 0, 1, 0, 16'h0000, 16'h0000, 0);
    #5 clr_n = 1'b1;

    drive(1, 0, 16'h0003, 16'h0001);
    drive(0, 0, 16'h0003, 16'h0001);
    push("ld3", 1, 1, 0, 16'h0003, 16'h0000, 2);
    drive(1, 1, 16'hFFFF, 16'h0001);
    drive(0, 0, 16'hFFFF, 16'h0003);
    push("collide", 1, 1, 2, 16'h0003, 16'h0001, 1);
    drive(0, 1, 16'hFFFF, 16'h0003);
    drive(0, 0, 16'hFFFF, 16'h0007);
    push("sink2", 0, 0, 2, 16'h0003, 16'h0003, 0);

    drive(0, 0, 16'hFFFF, 16'h0002);
    clr_n = 1'b0;
    push("rst_async", 1, 1, 0, 16'h0000, 16'h0000, 0);
    #5 clr_n = 1'b1;
    drive(0, 1, 16'hFFFF, 16'h0002);
    drive(0, 0, 16'h0000, 16'h0002);
    push("empty_map", 0, 0, 1, 16'h0000, 16'h0002, 0);

    drive(0, 0, 16'h0000, 16'h0000);
    clr_n = 1'b0;
    #5 clr_n = 1'b1;
    drive(1, 0, 16'h0001, 16'h0006);
    drive(0, 1, 16'h0001, 16'h0006);
    drive(1, 0, 16'hFFFF, 16'h0002);
    push("bad_setup", 1, 1, 3, 16'h0001, 16'h0000, 1);
    drive(0, 0, 16'hFFFF, 16'h0002);
    push("ld_ignored", 1, 1, 3, 16'h0001, 16'h0000, 1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, want 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
